// File: rtl/hex_keypad_entry.sv
// hex_keypad_entry: scans a 4x4 hex keypad, debounces presses and shifts each accepted digit
// into a 4-digit entry register. Enter commits the entry to Data with a one-cycle Load strobe
// (the Data/Load pair the 7-segment display interface latches); Clear zeroes the entry.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   Row_In       keypad rows, active-low, asynchronous
//   Col_Drive    keypad columns, active-low one-hot
//   Btn_Enter    Enter button, active-high, asynchronous
//   Btn_Clear    Clear button, active-high, asynchronous
//   Entry        live entry register, newest digit in [3:0]
//   Digit_Count  digits entered since clear, saturates at 4
//   Key_Valid    one-cycle pulse per accepted key
//   Key_Code     code (4*row + col) of last accepted key
//   Data         committed word for the display path
//   Load         one-cycle commit strobe
module hex_keypad_entry #(
  parameter int unsigned ANCHO        = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CNT = 500000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            Row_In,
  output logic [3:0]            Col_Drive,
  input  logic                  Btn_Enter,
  input  logic                  Btn_Clear,
  output logic [2**ANCHO-1:0]   Entry,
  output logic [2:0]            Digit_Count,
  output logic                  Key_Valid,
  output logic [3:0]            Key_Code,
  output logic [2**ANCHO-1:0]   Data,
  output logic                  Load
);

  localparam int unsigned Width  = 2 ** ANCHO;
  localparam int unsigned DwellW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DebW   = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
  localparam logic [DebW-1:0]   DebLast   = DebW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {StScan, StDebounce, StHeld, StRelease} state_e;

  // Synchronizers and button filters
  logic [3:0]      row_s1_q, row_s2_q;
  logic [1:0]      btn_raw;
  logic [1:0]      btn_s1_q, btn_s2_q, btn_filt_q, btn_prev_q;
  logic [DebW-1:0] btn_cnt_q [2];
  logic [1:0]      btn_edge;
  logic            enter_edge, clear_edge;

  // Bit 0 is Enter, bit 1 is Clear; both share one filter structure.
  assign btn_raw = {Btn_Clear, Btn_Enter};

  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1_q   <= 4'hF;
      row_s2_q   <= 4'hF;
      btn_s1_q   <= '1;
      btn_s2_q   <= '1;
      btn_filt_q <= '1;
      btn_prev_q <= '1;
      for (int b = 0; b < 2; b++) btn_cnt_q[b] <= '0;
    end else begin
      row_s1_q   <= Row_In;
      row_s2_q   <= row_s1_q;
      btn_s1_q   <= btn_raw;
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_filt_q;
      // The filtered level only follows sync2 after DEBOUNCE_CNT consecutive differing cycles.
      for (int b = 0; b < 2; b++) begin
        if (btn_s2_q[b] == btn_filt_q[b]) begin
          btn_cnt_q[b] <= '0;
        end else if (btn_cnt_q[b] == DebLast) begin
          btn_filt_q[b] <= btn_s2_q[b];
          btn_cnt_q[b]  <= '0;
        end else begin
          btn_cnt_q[b] <= btn_cnt_q[b] + DebW'(1);
        end
      end
    end
  end

  assign btn_edge   = btn_filt_q & ~btn_prev_q;
  assign enter_edge = btn_edge[0];
  assign clear_edge = btn_edge[1];

  // Scan / debounce FSM
  state_e            state_q, state_d;
  logic [1:0]        col_q, col_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [DebW-1:0]   deb_q, deb_d;
  logic [3:0]        code_lat_q, code_lat_d;
  logic [1:0]        row_idx;
  logic              row_low;
  logic              accept;

  // Lowest-index low row wins when several are pressed.
  always_comb begin
    row_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s2_q[i]) row_idx = 2'(i);
    end
  end

  assign row_low   = ~row_s2_q[code_lat_q[3:2]];
  assign Col_Drive = ~(4'b0001 << col_q);

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    dwell_d    = dwell_q;
    deb_d      = deb_q;
    code_lat_d = code_lat_q;
    accept     = 1'b0;
    unique case (state_q)
      StScan: begin
        if (dwell_q == DwellLast) begin
          dwell_d = '0;
          if (row_s2_q != 4'hF) begin
            // Column stays frozen while the press is qualified.
            code_lat_d = {row_idx, col_q};
            deb_d      = '0;
            state_d    = StDebounce;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + DwellW'(1);
        end
      end
      StDebounce: begin
        if (row_low) begin
          if (deb_q == DebLast) begin
            accept  = 1'b1;
            state_d = StHeld;
          end else begin
            deb_d = deb_q + DebW'(1);
          end
        end else begin
          state_d = StScan;
          col_d   = col_q + 2'd1;
          dwell_d = '0;
        end
      end
      StHeld: begin
        if (!row_low) begin
          deb_d   = '0;
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (row_low) begin
          deb_d = '0;
        end else if (deb_q == DebLast) begin
          state_d = StScan;
          col_d   = col_q + 2'd1;
          dwell_d = '0;
        end else begin
          deb_d = deb_q + DebW'(1);
        end
      end
      default: state_d = StScan;
    endcase
  end

  // Entry / commit datapath
  logic [Width-1:0] entry_q, entry_d;
  logic [Width-1:0] data_q, data_d;
  logic [2:0]       count_q, count_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             load_q, load_d;

  always_comb begin
    entry_d     = entry_q;
    count_d     = count_q;
    data_d      = data_q;
    load_d      = enter_edge;
    key_valid_d = accept;
    key_code_d  = accept ? code_lat_q : key_code_q;
    // Enter always captures the pre-update entry.
    if (enter_edge) data_d = entry_q;
    if (clear_edge) begin
      entry_d = '0;
      count_d = 3'd0;
    end else if (accept) begin
      entry_d = {entry_q[Width-5:0], code_lat_q};
      count_d = (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StScan;
      col_q       <= 2'd0;
      dwell_q     <= '0;
      deb_q       <= '0;
      code_lat_q  <= 4'd0;
      entry_q     <= '0;
      data_q      <= '0;
      count_q     <= 3'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      load_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      dwell_q     <= dwell_d;
      deb_q       <= deb_d;
      code_lat_q  <= code_lat_d;
      entry_q     <= entry_d;
      data_q      <= data_d;
      count_q     <= count_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      load_q      <= load_d;
    end
  end

  assign Entry       = entry_q;
  assign Digit_Count = count_q;
  assign Key_Valid   = key_valid_q;
  assign Key_Code    = key_code_q;
  assign Data        = data_q;
  assign Load        = load_q;

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Testbench for hex_keypad_entry: a keypad model drives rows from the driven column, a monitor
// counts Key_Valid / Load pulses, and a digit-level reference model tracks Entry/Data.
module tb_hex_keypad_entry;

  localparam int unsigned ScanDiv = 4;
  localparam int unsigned DebCnt  = 8;

  logic        clk;
  logic        rst;
  logic [3:0]  Row_In;
  logic [3:0]  Col_Drive;
  logic        Btn_Enter, Btn_Clear;
  logic [15:0] Entry, Data;
  logic [2:0]  Digit_Count;
  logic        Key_Valid, Load;
  logic [3:0]  Key_Code;

  hex_keypad_entry #(
    .ANCHO       (4),
    .SCAN_DIV    (ScanDiv),
    .DEBOUNCE_CNT(DebCnt)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Row_In     (Row_In),
    .Col_Drive  (Col_Drive),
    .Btn_Enter  (Btn_Enter),
    .Btn_Clear  (Btn_Clear),
    .Entry      (Entry),
    .Digit_Count(Digit_Count),
    .Key_Valid  (Key_Valid),
    .Key_Code   (Key_Code),
    .Data       (Data),
    .Load       (Load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a pressed key pulls its row low only while its column is driven.
  logic       key_down, raw_mode;
  logic [1:0] key_row, key_col;
  logic [3:0] raw_rows;

  always_comb begin
    Row_In = 4'hF;
    if (raw_mode) Row_In = raw_rows;
    else if (key_down && !Col_Drive[key_col]) Row_In[key_row] = 1'b0;
  end

  // Monitor
  int          kv_count, load_count;
  logic [3:0]  last_kv_code;
  logic [15:0] load_data, load_entry;

  initial begin
    kv_count = 0;
    load_count = 0;
    last_kv_code = 4'd0;
    load_data = 16'd0;
    load_entry = 16'd0;
  end

  always @(negedge clk) begin
    if (Key_Valid) begin
      kv_count++;
      last_kv_code = Key_Code;
    end
    if (Load) begin
      load_count++;
      load_data  = Data;
      load_entry = Entry;
    end
  end

  int          n_checks, n_errors;
  logic [15:0] m_entry, m_data;
  logic [2:0]  m_count;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_key(input int code);
    m_entry = {m_entry[11:0], 4'(code)};
    m_count = (m_count == 3'd4) ? 3'd4 : m_count + 3'd1;
  endtask

  task automatic press_key(input int row, input int col, input int hold);
    key_row  = 2'(row);
    key_col  = 2'(col);
    key_down = 1'b1;
    repeat (hold) tick();
    key_down = 1'b0;
    repeat (24) tick();
  endtask

  task automatic press_button(input logic enter, input logic clear);
    Btn_Enter = enter;
    Btn_Clear = clear;
    repeat (14) tick();
    Btn_Enter = 1'b0;
    Btn_Clear = 1'b0;
    repeat (14) tick();
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    n_checks++;
    if (Entry !== 16'h0 || Data !== 16'h0 || Digit_Count !== 3'd0) begin
      n_errors++;
      $display("FAIL reset_regs: Entry=%h Data=%h Count=%0d, required all zero", Entry, Data,
               Digit_Count);
    end
    n_checks++;
    if (Load !== 1'b0 || Key_Valid !== 1'b0 || Key_Code !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_strobes: Load=%b Key_Valid=%b Key_Code=%h, required 0", Load,
               Key_Valid, Key_Code);
    end
    for (int i = 0; i < 16; i++) begin
      exp_col = ~(4'b0001 << ((i / ScanDiv) % 4));
      n_checks++;
      if (Col_Drive !== exp_col) begin
        n_errors++;
        $display("FAIL reset_scan[%0d]: Col_Drive=%b required %b", i, Col_Drive, exp_col);
      end
      tick();
    end
  endtask

  task automatic test_single_key();
    int  kv0;
    logic seen, moved;
    kv0 = kv_count;
    seen = 1'b0;
    moved = 1'b0;
    key_row = 2'd1;
    key_col = 2'd2;
    key_down = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (Key_Valid && !seen) begin
        seen = 1'b1;
        n_checks++;
        if (Key_Code !== 4'd6 || Col_Drive !== 4'b1011) begin
          n_errors++;
          $display("FAIL single_code: Key_Code=%h Col_Drive=%b required 6 / 1011", Key_Code,
                   Col_Drive);
        end
      end
    end
    n_checks++;
    if (Col_Drive !== 4'b1011) begin
      n_errors++;
      $display("FAIL single_frozen_held: Col_Drive=%b required 1011", Col_Drive);
    end
    key_down = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (Col_Drive !== 4'b1011) begin
      n_errors++;
      $display("FAIL single_frozen_release: Col_Drive=%b required 1011", Col_Drive);
    end
    for (int i = 0; i < 24; i++) begin
      tick();
      if (Col_Drive !== 4'b1011) moved = 1'b1;
    end
    n_checks++;
    if (!moved) begin
      n_errors++;
      $display("FAIL single_rescan: Col_Drive stuck at %b, required scanning to resume",
               Col_Drive);
    end
    model_key(6);
    n_checks++;
    if (kv_count - kv0 != 1 || Entry !== m_entry || Digit_Count !== m_count) begin
      n_errors++;
      $display("FAIL single_entry: pulses=%0d Entry=%h Count=%0d required 1 / %h / %0d",
               kv_count - kv0, Entry, Digit_Count, m_entry, m_count);
    end
  endtask

  task automatic test_sequence();
    int kv0, l0, n;
    logic found;
    press_button(1'b0, 1'b1);
    m_entry = 16'h0;
    m_count = 3'd0;
    n_checks++;
    if (Entry !== 16'h0 || Digit_Count !== 3'd0) begin
      n_errors++;
      $display("FAIL seq_clear: Entry=%h Count=%0d required 0 / 0", Entry, Digit_Count);
    end
    kv0 = kv_count;
    for (int k = 1; k <= 5; k++) begin
      press_key(k / 4, k % 4, 40);
      model_key(k);
      n_checks++;
      if (Key_Code !== 4'(k) || Entry !== m_entry || Digit_Count !== m_count) begin
        n_errors++;
        $display("FAIL seq_key%0d: code=%h Entry=%h Count=%0d required %h / %h / %0d", k,
                 Key_Code, Entry, Digit_Count, 4'(k), m_entry, m_count);
      end
    end
    n_checks++;
    if (Entry !== 16'h2345 || Digit_Count !== 3'd4 || kv_count - kv0 != 5) begin
      n_errors++;
      $display("FAIL seq_overflow: Entry=%h Count=%0d pulses=%0d required 2345 / 4 / 5", Entry,
               Digit_Count, kv_count - kv0);
    end
    // Enter latency: Load on the (3 + DEBOUNCE_CNT)th edge after the button goes high.
    l0 = load_count;
    Btn_Enter = 1'b1;
    n = 0;
    found = 1'b0;
    while (!found && n < 40) begin
      tick();
      n++;
      if (Load) found = 1'b1;
    end
    n_checks++;
    if (!found || n != 3 + int'(DebCnt)) begin
      n_errors++;
      $display("FAIL seq_enter_latency: Load after %0d edges (found=%b) required %0d", n, found,
               3 + DebCnt);
    end
    n_checks++;
    if (Data !== m_entry) begin
      n_errors++;
      $display("FAIL seq_enter_data: Data=%h required %h", Data, m_entry);
    end
    m_data = m_entry;
    repeat (6) tick();
    Btn_Enter = 1'b0;
    repeat (14) tick();
    n_checks++;
    if (load_count - l0 != 1 || Entry !== m_entry) begin
      n_errors++;
      $display("FAIL seq_enter_once: loads=%0d Entry=%h required 1 / %h", load_count - l0,
               Entry, m_entry);
    end
  endtask

  task automatic test_bounce();
    int kv0, n;
    logic [3:0] prev, code;
    logic found;
    raw_mode = 1'b1;
    raw_rows = 4'hF;
    prev = Col_Drive;
    n = 0;
    found = 1'b0;
    while (!found && n < 40) begin
      tick();
      n++;
      if (Col_Drive == 4'b1110 && prev != 4'b1110) found = 1'b1;
      prev = Col_Drive;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL bounce_sync: Col_Drive=%b never entered 1110 within 40 cycles", Col_Drive);
    end
    kv0 = kv_count;
    raw_rows = 4'b1101;
    repeat (3) tick();
    raw_rows = 4'hF;
    repeat (2) tick();
    raw_rows = 4'b1101;
    repeat (20) tick();
    raw_rows = 4'hF;
    repeat (24) tick();
    code = last_kv_code;
    n_checks++;
    if (kv_count - kv0 != 1 || code[3:2] !== 2'd1) begin
      n_errors++;
      $display("FAIL bounce_one: pulses=%0d row=%0d required 1 / 1", kv_count - kv0, code[3:2]);
    end
    kv0 = kv_count;
    raw_rows = 4'b1101;
    repeat (5) tick();
    raw_rows = 4'hF;
    repeat (24) tick();
    n_checks++;
    if (kv_count - kv0 != 0) begin
      n_errors++;
      $display("FAIL bounce_short: pulses=%0d required 0", kv_count - kv0);
    end
    raw_mode = 1'b0;
  endtask

  task automatic test_clear_enter();
    int l0;
    press_button(1'b0, 1'b1);
    m_entry = 16'h0;
    m_count = 3'd0;
    press_key(2, 2, 40);
    model_key(10);
    press_key(2, 3, 40);
    model_key(11);
    n_checks++;
    if (Entry !== 16'h00AB || Entry !== m_entry) begin
      n_errors++;
      $display("FAIL clr_setup: Entry=%h required 00ab", Entry);
    end
    l0 = load_count;
    press_button(1'b1, 1'b1);
    n_checks++;
    if (load_count - l0 != 1 || load_data !== 16'h00AB || load_entry !== 16'h0) begin
      n_errors++;
      $display("FAIL clr_enter_same: loads=%0d Data=%h Entry@load=%h required 1 / 00ab / 0",
               load_count - l0, load_data, load_entry);
    end
    n_checks++;
    if (Entry !== 16'h0 || Digit_Count !== 3'd0 || Data !== 16'h00AB) begin
      n_errors++;
      $display("FAIL clr_after: Entry=%h Count=%0d Data=%h required 0 / 0 / 00ab", Entry,
               Digit_Count, Data);
    end
    m_entry = 16'h0;
    m_count = 3'd0;
    m_data = 16'h00AB;
  endtask

  task automatic test_random();
    int op, code, kv0, l0;
    for (int it = 0; it < 12; it++) begin
      op = int'($urandom_range(0, 7));
      if (op == 0) begin
        press_button(1'b0, 1'b1);
        m_entry = 16'h0;
        m_count = 3'd0;
        n_checks++;
        if (Entry !== m_entry || Digit_Count !== m_count) begin
          n_errors++;
          $display("FAIL rand_clear[%0d]: Entry=%h Count=%0d required 0 / 0", it, Entry,
                   Digit_Count);
        end
      end else if (op == 1) begin
        l0 = load_count;
        press_button(1'b1, 1'b0);
        m_data = m_entry;
        n_checks++;
        if (load_count - l0 != 1 || Data !== m_data || Entry !== m_entry) begin
          n_errors++;
          $display("FAIL rand_enter[%0d]: loads=%0d Data=%h Entry=%h required 1 / %h / %h", it,
                   load_count - l0, Data, Entry, m_data, m_entry);
        end
      end else begin
        code = int'($urandom_range(0, 15));
        kv0 = kv_count;
        press_key(code / 4, code % 4, int'($urandom_range(40, 52)));
        model_key(code);
        n_checks++;
        if (kv_count - kv0 != 1 || Key_Code !== 4'(code) || Entry !== m_entry ||
            Digit_Count !== m_count || Data !== m_data) begin
          n_errors++;
          $display("FAIL rand_key[%0d]: pulses=%0d code=%h Entry=%h Count=%0d Data=%h required 1 / %h / %h / %0d / %h",
                   it, kv_count - kv0, Key_Code, Entry, Digit_Count, Data, 4'(code), m_entry,
                   m_count, m_data);
        end
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    int kv0, n;
    logic [3:0] prev;
    logic found;
    prev = Col_Drive;
    n = 0;
    found = 1'b0;
    while (!found && n < 40) begin
      tick();
      n++;
      if (Col_Drive == 4'b1101 && prev != 4'b1101) found = 1'b1;
      prev = Col_Drive;
    end
    kv0 = kv_count;
    key_row = 2'd1;
    key_col = 2'd2;
    key_down = 1'b1;
    n = 0;
    while (found && Col_Drive != 4'b1011 && n < 40) begin
      tick();
      n++;
    end
    repeat (8) tick();
    n_checks++;
    if (!found || Col_Drive !== 4'b1011 || kv_count != kv0) begin
      n_errors++;
      $display("FAIL rmd_in_debounce: found=%b Col_Drive=%b pulses=%0d required 1 / 1011 / 0",
               found, Col_Drive, kv_count - kv0);
    end
    rst = 1'b1;
    key_down = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    n_checks++;
    if (Col_Drive !== 4'b1110 || Entry !== 16'h0 || Digit_Count !== 3'd0) begin
      n_errors++;
      $display("FAIL rmd_after_reset: Col_Drive=%b Entry=%h Count=%0d required 1110 / 0 / 0",
               Col_Drive, Entry, Digit_Count);
    end
    repeat (30) tick();
    n_checks++;
    if (kv_count != kv0 || Entry !== 16'h0) begin
      n_errors++;
      $display("FAIL rmd_no_key: pulses=%0d Entry=%h required 0 / 0", kv_count - kv0, Entry);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    key_down = 1'b0;
    raw_mode = 1'b0;
    raw_rows = 4'hF;
    key_row = 2'd0;
    key_col = 2'd0;
    Btn_Enter = 1'b0;
    Btn_Clear = 1'b0;
    m_entry = 16'h0;
    m_data = 16'h0;
    m_count = 3'd0;
    test_reset();
    repeat (12) tick();
    test_single_key();
    test_sequence();
    test_bounce();
    test_clear_enter();
    test_random();
    test_reset_mid_debounce();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
